// File: rtl/regaccess_pkg.sv
// Shared constants, FSM state encoding and frame builder for the register-access SPI host.
package regaccess_pkg;

    localparam int FRAME_BITS = 16;
    localparam int RW_BIT     = 7;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        SHIFT_HI = 3'd2,
        SHIFT_LO = 3'd3,
        HOLD     = 3'd4,
        GAP      = 3'd5
    } state_e;

    localparam logic [6:0] VERSION             = 7'h00;
    localparam logic [6:0] STATUS_CONTROL      = 7'h01;
    localparam logic [6:0] CHANNEL_SELECT_LOW  = 7'h02;
    localparam logic [6:0] CHANNEL_SELECT_HIGH = 7'h03;
    localparam logic [6:0] SAMPLE_RATE_DIVISOR = 7'h04;
    localparam logic [6:0] LED_BRIGHTNESS      = 7'h05;
    localparam logic [6:0] MODE                = 7'h0a;
    localparam logic [6:0] SCRATCHPAD          = 7'h0d;

    // Byte 0 carries the R/W flag above the register number; reads send a zero data byte.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic       wr,
                                                           input logic [6:0] regnum,
                                                           input logic [7:0] wdata);
        logic [7:0] hdr;
        hdr         = {1'b0, regnum};
        hdr[RW_BIT] = wr;
        return {hdr, (wr ? wdata : 8'h00)};
    endfunction

endpackage

// File: rtl/regaccess_if.sv
// Command/response handshake between a requester (master) and the SPI host (slave).
interface regaccess_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [6:0] cmd_regnum;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;

    modport master (
        output cmd_valid, cmd_write, cmd_regnum, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_regnum, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, busy
    );

endinterface

// File: rtl/regaccess_host_spi_phase_timer.sv
// Loadable down-counter; tc_o marks the last cycle of a phase loaded with (length-1).
module spi_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/regaccess_host.sv
// SPI mode-0 master issuing one 16-bit register read/write frame per accepted command.
module regaccess_host
    import regaccess_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    regaccess_if.slave bus,
    output logic       ss,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    localparam int MAX_PH = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int PW     = $clog2(MAX_PH + 1);
    localparam logic [PW-1:0] DIV_LOAD = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] GAP_LOAD = PW'(GAP_CYCLES - 1);

    localparam logic [2:0] S_IDLE     = IDLE;
    localparam logic [2:0] S_SETUP    = SETUP;
    localparam logic [2:0] S_SHIFT_HI = SHIFT_HI;
    localparam logic [2:0] S_SHIFT_LO = SHIFT_LO;
    localparam logic [2:0] S_HOLD     = HOLD;
    localparam logic [2:0] S_GAP      = GAP;

    logic [2:0]            state_q, state_d;
    logic                  ss_q, ss_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  rvld_q, rvld_d;
    logic [7:0]            rdata_q, rdata_d;
    logic [4:0]            bit_q, bit_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [7:0]            rx_q, rx_d;
    logic                  miso_meta_q, miso_sync_q;
    logic                  ld;
    logic [PW-1:0]         ld_val;
    logic                  tc;
    logic                  accept;

    assign bus.cmd_ready = rst_n && (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.rsp_valid = rvld_q;
    assign bus.rsp_rdata = rdata_q;
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign ss            = ss_q;
    assign sclk          = sclk_q;
    assign mosi          = mosi_q;

    spi_phase_timer #(.W(PW)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (ld),
        .load_val_i(ld_val),
        .tc_o      (tc)
    );

    always_comb begin
        state_d = state_q;
        ss_d    = ss_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        rvld_d  = 1'b0;
        rdata_d = rdata_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        ld      = 1'b0;
        ld_val  = DIV_LOAD;
        case (state_q)
            S_IDLE: if (accept) begin
                state_d = S_SETUP;
                ld      = 1'b1;
                tx_d    = build_frame(bus.cmd_write, bus.cmd_regnum, bus.cmd_wdata);
                mosi_d  = tx_d[FRAME_BITS-1];
                ss_d    = 1'b0;
                bit_d   = 5'd0;
            end
            S_SETUP: if (tc) begin
                state_d = S_SHIFT_HI;
                ld      = 1'b1;
                sclk_d  = 1'b1;
            end
            // Sample at the end of the high phase; the falling edge presents the next bit,
            // and the zero shifted in leaves mosi low once bit 0 has gone out.
            S_SHIFT_HI: if (tc) begin
                state_d = S_SHIFT_LO;
                ld      = 1'b1;
                sclk_d  = 1'b0;
                rx_d    = {rx_q[6:0], miso_sync_q};
                tx_d    = {tx_q[FRAME_BITS-2:0], 1'b0};
                mosi_d  = tx_q[FRAME_BITS-2];
                bit_d   = bit_q + 5'd1;
            end
            S_SHIFT_LO: if (tc) begin
                ld = 1'b1;
                if (bit_q == 5'(FRAME_BITS)) begin
                    state_d = S_HOLD;
                end else begin
                    state_d = S_SHIFT_HI;
                    sclk_d  = 1'b1;
                end
            end
            S_HOLD: if (tc) begin
                state_d = S_GAP;
                ld      = 1'b1;
                ld_val  = GAP_LOAD;
                ss_d    = 1'b1;
                rvld_d  = 1'b1;
                rdata_d = rx_q;
            end
            S_GAP: if (tc) begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ss_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            rvld_q  <= 1'b0;
            rdata_q <= 8'h00;
            bit_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            ss_q    <= ss_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            rvld_q  <= rvld_d;
            rdata_q <= rdata_d;
            bit_q   <= bit_d;
        end
    end

    // miso is asynchronous to clk: two flops before it reaches the receive shifter.
    always_ff @(posedge clk) begin
        miso_meta_q <= miso;
        miso_sync_q <= miso_meta_q;
        tx_q        <= tx_d;
        rx_q        <= rx_d;
    end

endmodule

// File: tb/tb_regaccess_host.sv
// Directed bench for regaccess_host with a behavioural SPI register-file slave.
module tb_regaccess_host;
    import regaccess_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sel = 1'b0;
    logic       cv = 1'b0, cw = 1'b0;
    logic [6:0] creg = 7'h00;
    logic [7:0] cwd = 8'h00;
    logic       ss0, sclk0, mosi0, ss1, sclk1, mosi1;
    logic       miso_s = 1'b0;

    regaccess_if bus0();
    regaccess_if bus1();

    regaccess_host #(.CLK_DIV(4), .GAP_CYCLES(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave),
        .ss(ss0), .sclk(sclk0), .mosi(mosi0), .miso(miso_s));
    regaccess_host #(.CLK_DIV(7), .GAP_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
        .ss(ss1), .sclk(sclk1), .mosi(mosi1), .miso(miso_s));

    always #5 clk = ~clk;

    assign bus0.cmd_valid  = cv & ~sel;
    assign bus1.cmd_valid  = cv & sel;
    assign bus0.cmd_write  = cw;
    assign bus1.cmd_write  = cw;
    assign bus0.cmd_regnum = creg;
    assign bus1.cmd_regnum = creg;
    assign bus0.cmd_wdata  = cwd;
    assign bus1.cmd_wdata  = cwd;

    logic       ss_m, sclk_m, mosi_m, rdy_m, rv_m, busy_m;
    logic [7:0] rdata_m;
    assign ss_m    = sel ? ss1 : ss0;
    assign sclk_m  = sel ? sclk1 : sclk0;
    assign mosi_m  = sel ? mosi1 : mosi0;
    assign rdy_m   = sel ? bus1.cmd_ready : bus0.cmd_ready;
    assign rv_m    = sel ? bus1.rsp_valid : bus0.rsp_valid;
    assign busy_m  = sel ? bus1.busy : bus0.busy;
    assign rdata_m = sel ? bus1.rsp_rdata : bus0.rsp_rdata;

    // Slave register file: returns the current register contents in byte 1 and
    // commits a write at the 16th rising edge.
    logic [7:0]  regs [128];
    logic [15:0] sh = 16'h0;
    logic [7:0]  rd = 8'h0;
    int          nb = 0;

    always @(posedge sclk_m or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 128; i++) regs[i] = 8'h00;
            regs[0]   = 8'h10;
            regs[4]   = 8'h3C;
            regs[13]  = 8'h73;
            regs[127] = 8'h81;
            nb = 0;
        end else if (!ss_m) begin
            sh = {sh[14:0], mosi_m};
            nb = nb + 1;
            if (nb == 16) begin
                if (sh[15]) regs[sh[14:8]] = sh[7:0];
                nb = 0;
            end
        end
    end

    always @(negedge sclk_m) begin
        if (nb == 8) rd = regs[sh[6:0]];
        if (nb >= 8) begin
            miso_s = rd[7];
            rd     = {rd[6:0], 1'b0};
        end else begin
            miso_s = 1'b0;
        end
    end

    // Bus monitor, sampled on the inactive clock edge.
    logic        clr_req = 1'b0;
    logic        sclk_p = 1'b0, ss_p = 1'b1;
    logic [15:0] mosi_cap = 16'h0;
    int cyc = 0, lowcnt = 0, rises = 0, rvcnt = 0, rv_bad = 0;
    int hi_run = 0, lo_run = 0, rise_cyc = 0, fall_cyc = 0;
    int hi_min = 0, hi_max = 0, lo_min = 0, lo_max = 0;

    always @(negedge clk) begin
        if (clr_req) begin
            lowcnt = 0; rises = 0; rvcnt = 0; rv_bad = 0; hi_run = 0; lo_run = 0;
            hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0; mosi_cap = 16'h0;
        end else begin
            cyc = cyc + 1;
            if (!ss_m && ss_p) begin fall_cyc = cyc; lo_run = 0; end
            if (ss_m && !ss_p) rise_cyc = cyc;
            if (sclk_m && !sclk_p) begin
                rises = rises + 1;
                mosi_cap = {mosi_cap[14:0], mosi_m};
                if (lo_run < lo_min) lo_min = lo_run;
                if (lo_run > lo_max) lo_max = lo_run;
                lo_run = 0;
            end
            if (!sclk_m && sclk_p) begin
                if (hi_run < hi_min) hi_min = hi_run;
                if (hi_run > hi_max) hi_max = hi_run;
                hi_run = 0;
            end
            if (!ss_m) begin
                lowcnt = lowcnt + 1;
                if (sclk_m) hi_run = hi_run + 1; else lo_run = lo_run + 1;
            end
            if (rv_m) begin
                rvcnt = rvcnt + 1;
                if (!(ss_m && !ss_p)) rv_bad = rv_bad + 1;
            end
        end
        sclk_p = sclk_m;
        ss_p   = ss_m;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", nm);
    endtask

    task automatic nclk();
        @(negedge clk);
        #1;
    endtask

    task automatic clear();
        clr_req = 1'b1;
        nclk();
        clr_req = 1'b0;
    endtask

    task automatic start_cmd(input logic w, input logic [6:0] r, input logic [7:0] d, input logic keep);
        int n;
        clear();
        cw = w; creg = r; cwd = d; cv = 1'b1;
        n = 0;
        while (!rdy_m && n < 300) begin nclk(); n++; end
        if (!rdy_m) timeout("accept");
        @(posedge clk);
        #1;
        if (!keep) begin
            cv = 1'b0; cw = ~w; creg = ~r; cwd = ~d;
        end
    endtask

    task automatic wait_rv(output logic [7:0] got);
        int n;
        n = 0;
        got = 8'h00;
        while (!rv_m && n < 1000) begin nclk(); n++; end
        if (!rv_m) timeout("rsp_valid");
        else got = rdata_m;
        nclk();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_m && n < 1000) begin nclk(); n++; end
        if (busy_m) timeout("idle");
        nclk();
    endtask

    typedef struct {
        logic        w;
        logic [6:0]  r;
        logic [7:0]  d;
        logic [15:0] exp_mosi;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] got, got2;
    int         bad;

    initial begin
        vecs[0] = '{1'b0, VERSION,        8'h00, 16'h0000, 8'h10};
        vecs[1] = '{1'b1, SCRATCHPAD,     8'hA5, 16'h8DA5, 8'h73};
        vecs[2] = '{1'b0, SCRATCHPAD,     8'h00, 16'h0D00, 8'hA5};
        vecs[3] = '{1'b1, LED_BRIGHTNESS, 8'h3F, 16'h853F, 8'h00};
        vecs[4] = '{1'b0, LED_BRIGHTNESS, 8'h00, 16'h0500, 8'h3F};
        vecs[5] = '{1'b0, 7'h7f,          8'h00, 16'h7F00, 8'h81};
        vecs[6] = '{1'b1, 7'h7f,          8'hFF, 16'hFFFF, 8'h81};
        vecs[7] = '{1'b0, 7'h7f,          8'h00, 16'h7F00, 8'hFF};

        #1 rst_n = 1'b0;
        #12;
        chk("rst_ss", int'(ss_m), 1);
        chk("rst_sclk", int'(sclk_m), 0);
        chk("rst_mosi", int'(mosi_m), 0);
        chk("rst_ready", int'(rdy_m), 0);
        chk("rst_rsp_valid", int'(rv_m), 0);
        chk("rst_rdata", int'(rdata_m), 0);
        chk("rst_busy", int'(busy_m), 0);
        nclk();
        rst_n = 1'b1;
        #1 chk("ready_after_rst", int'(rdy_m), 1);

        for (int i = 0; i < 8; i++) begin
            start_cmd(vecs[i].w, vecs[i].r, vecs[i].d, 1'b0);
            wait_rv(got);
            wait_idle();
            chk($sformatf("v%0d_mosi", i), int'(mosi_cap), int'(vecs[i].exp_mosi));
            chk($sformatf("v%0d_rdata", i), int'(got), int'(vecs[i].exp_rdata));
            chk($sformatf("v%0d_ss_low", i), lowcnt, 136);
            chk($sformatf("v%0d_rises", i), rises, 16);
            chk($sformatf("v%0d_rsp_count", i), rvcnt, 1);
            chk($sformatf("v%0d_rsp_vs_ss", i), rv_bad, 0);
        end

        // Back-to-back: cmd_valid held, fields changed after the first acceptance.
        start_cmd(1'b0, VERSION, 8'h00, 1'b1);
        creg = SCRATCHPAD;
        wait_rv(got);
        bad = 0;
        while (ss_m && bad < 100) begin nclk(); bad++; end
        cv = 1'b0;
        chk("b2b_gap", fall_cyc - rise_cyc, 5);
        wait_rv(got2);
        wait_idle();
        repeat (30) nclk();
        chk("b2b_first", int'(got), 8'h10);
        chk("b2b_second", int'(got2), 8'hA5);
        chk("b2b_count", rvcnt, 2);

        // Reset during the ninth sclk high phase.
        start_cmd(1'b0, SCRATCHPAD, 8'h00, 1'b0);
        bad = 0;
        while (rises < 9 && bad < 2000) begin nclk(); bad++; end
        if (rises < 9) timeout("sclk_edge9");
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_ss", int'(ss_m), 1);
        chk("midrst_sclk", int'(sclk_m), 0);
        chk("midrst_rdata", int'(rdata_m), 0);
        bad = 0;
        repeat (5) begin
            nclk();
            if (rdy_m || busy_m || rv_m) bad++;
        end
        chk("midrst_outputs_low", bad, 0);
        rst_n = 1'b1;
        #1 chk("midrst_ready", int'(rdy_m), 1);
        chk("midrst_no_rsp", rvcnt, 0);

        // Command presented while busy is dropped, not queued.
        start_cmd(1'b0, VERSION, 8'h00, 1'b0);
        repeat (40) nclk();
        cw = 1'b1; creg = SCRATCHPAD; cwd = 8'h55; cv = 1'b1;
        repeat (30) nclk();
        cv = 1'b0;
        wait_rv(got);
        wait_idle();
        repeat (30) nclk();
        chk("busy_ign_rdata", int'(got), 8'h10);
        chk("busy_ign_count", rvcnt, 1);

        start_cmd(1'b0, SCRATCHPAD, 8'h00, 1'b0);
        wait_rv(got);
        wait_idle();
        chk("scratch_after_rst", int'(got), 8'h73);
        chk("scratch_ss_low", lowcnt, 136);

        // Second instance: CLK_DIV=7, GAP_CYCLES=1.
        sel = 1'b1;
        nclk();
        start_cmd(1'b0, SAMPLE_RATE_DIVISOR, 8'h00, 1'b0);
        wait_rv(got);
        wait_idle();
        chk("div7_rdata", int'(got), 8'h3C);
        chk("div7_mosi", int'(mosi_cap), 16'h0400);
        chk("div7_ss_low", lowcnt, 238);
        chk("div7_rises", rises, 16);
        chk("div7_hi_min", hi_min, 7);
        chk("div7_hi_max", hi_max, 7);
        chk("div7_lo_min", lo_min, 7);
        chk("div7_lo_max", lo_max, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
